rdma_rx_psn_chk: RTL and testbench

- RC receive-side sequence checker. Sits directly downstream of the rx register slice and consumes its rx_out_valid/rx_out_data/rx_out_last beat stream.
- Parses the header beat of each packet and checks QP number and PSN against the expected PSN (ePSN).
- Forwards payload of in-sequence packets and drops everything else.
- Raises ACK, duplicate-ACK and sequence-NAK requests toward the tx responder through a valid/ready handshake.

---
 rtl/rdma_rx_pkg.sv | 50 +++++
 rtl/rdma_ack_slot.sv | 39 +++
 rtl/rdma_rx_psn_chk.sv | 166 ++++++++++++++++
 tb/tb_rdma_rx_psn_chk.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rdma_rx_pkg.sv
// Shared constants and types for the RC receive-side PSN checker.
// Header field positions, PSN window, FSM and ACK type encodings.
package rdma_rx_pkg;

    localparam int unsigned PSN_W = 24;
    localparam logic [PSN_W-1:0] PSN_HALF = 24'h800000;

    localparam int unsigned HDR_OPC_HI = 63;
    localparam int unsigned HDR_OPC_LO = 56;
    localparam int unsigned HDR_QP_HI  = 55;
    localparam int unsigned HDR_QP_LO  = 32;
    localparam int unsigned HDR_ACKREQ = 31;
    localparam int unsigned HDR_PSN_HI = 23;
    localparam int unsigned HDR_PSN_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    typedef enum logic {
        ACK_T_ACK = 1'b0,
        ACK_T_NAK = 1'b1
    } ack_type_e;

    typedef enum logic [1:0] {
        CLS_ACCEPT  = 2'd0,
        CLS_DUP     = 2'd1,
        CLS_AHEAD   = 2'd2,
        CLS_QP_MISS = 2'd3
    } hdr_class_e;

    // Distance ePSN - PSN modulo 2^24; up to half the space behind counts as duplicate.
    function automatic hdr_class_e classify(input logic qp_match,
                                            input logic [PSN_W-1:0] epsn,
                                            input logic [PSN_W-1:0] psn);
        logic [PSN_W-1:0] d;
        d = epsn - psn;
        if (!qp_match)
            return CLS_QP_MISS;
        else if (d == '0)
            return CLS_ACCEPT;
        else if (d <= PSN_HALF)
            return CLS_DUP;
        else
            return CLS_AHEAD;
    endfunction

endpackage

// File: rtl/rdma_ack_slot.sv
// Single-entry coalescing holding register for ACK/NAK requests.
// A new request always overwrites the pending one, even in the acceptance cycle.
module rdma_ack_slot
    import rdma_rx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    input  logic             req_nak_i,
    input  logic [PSN_W-1:0] req_psn_i,
    input  logic             ack_ready_i,
    output logic             ack_valid_o,
    output logic             ack_nak_o,
    output logic [PSN_W-1:0] ack_psn_o
);

    logic             valid_q;
    logic             nak_q;
    logic [PSN_W-1:0] psn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            nak_q   <= 1'b0;
            psn_q   <= '0;
        end else if (req_valid_i) begin
            valid_q <= 1'b1;
            nak_q   <= req_nak_i;
            psn_q   <= req_psn_i;
        end else if (valid_q && ack_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign ack_valid_o = valid_q;
    assign ack_nak_o   = nak_q;
    assign ack_psn_o   = psn_q;

endmodule

// File: rtl/rdma_rx_psn_chk.sv
// RC receive sequence checker: classifies header PSN against ePSN, forwards
// in-sequence payload one cycle late, and raises ACK/duplicate-ACK/NAK requests.
module rdma_rx_psn_chk
    import rdma_rx_pkg::*;
#(
    parameter logic [PSN_W-1:0] QPN      = 24'h000011,
    parameter logic [PSN_W-1:0] PSN_INIT = 24'h000000,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             pl_valid,
    output logic [63:0]      pl_data,
    output logic             pl_last,
    output logic             hdr_valid,
    output logic [7:0]       hdr_opcode,
    output logic             ack_valid,
    input  logic             ack_ready,
    output logic             ack_nak,
    output logic [PSN_W-1:0] ack_psn,
    output logic [PSN_W-1:0] epsn,
    output logic [CNT_W-1:0] drop_cnt
);

    rx_state_e        state_q;
    logic             nak_sent_q;
    logic             ackreq_q;
    logic [PSN_W-1:0] epsn_q, epsn_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             pl_valid_q, pl_last_q, hdr_valid_q;
    logic [63:0]      pl_data_q;
    logic [7:0]       hdr_opcode_q;

    logic [7:0]       h_opc;
    logic [PSN_W-1:0] h_qp, h_psn;
    logic             h_ackreq;
    hdr_class_e       cls;
    logic             is_hdr, pass_beat, pkt_done;
    logic             req_valid;
    ack_type_e        req_type;
    logic [PSN_W-1:0] req_psn;

    always_comb begin
        h_opc    = in_data[HDR_OPC_HI:HDR_OPC_LO];
        h_qp     = in_data[HDR_QP_HI:HDR_QP_LO];
        h_ackreq = in_data[HDR_ACKREQ];
        h_psn    = in_data[HDR_PSN_HI:HDR_PSN_LO];
        cls      = classify(h_qp == QPN, epsn_q, h_psn);

        is_hdr    = in_valid && (state_q == ST_IDLE);
        pass_beat = in_valid && (state_q == ST_PASS);
        pkt_done  = (is_hdr && (cls == CLS_ACCEPT) && in_last) || (pass_beat && in_last);

        epsn_d = pkt_done ? epsn_q + 1'b1 : epsn_q;

        drop_cnt_d = drop_cnt_q;
        if (is_hdr && (cls != CLS_ACCEPT) && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;

        // While a packet is in flight epsn_q still equals its PSN, so it doubles as the ACK PSN.
        req_valid = 1'b0;
        req_type  = ACK_T_ACK;
        req_psn   = '0;
        if (is_hdr) begin
            case (cls)
                CLS_ACCEPT: begin
                    if (in_last && h_ackreq) begin
                        req_valid = 1'b1;
                        req_psn   = h_psn;
                    end
                end
                CLS_DUP: begin
                    req_valid = 1'b1;
                    req_psn   = epsn_q - 1'b1;
                end
                CLS_AHEAD: begin
                    if (!nak_sent_q) begin
                        req_valid = 1'b1;
                        req_type  = ACK_T_NAK;
                        req_psn   = epsn_q;
                    end
                end
                default: ;
            endcase
        end else if (pass_beat && in_last && ackreq_q) begin
            req_valid = 1'b1;
            req_psn   = epsn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            nak_sent_q   <= 1'b0;
            ackreq_q     <= 1'b0;
            epsn_q       <= PSN_INIT;
            drop_cnt_q   <= '0;
            pl_valid_q   <= 1'b0;
            pl_data_q    <= '0;
            pl_last_q    <= 1'b0;
            hdr_valid_q  <= 1'b0;
            hdr_opcode_q <= '0;
        end else begin
            epsn_q      <= epsn_d;
            drop_cnt_q  <= drop_cnt_d;
            pl_valid_q  <= 1'b0;
            pl_last_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cls == CLS_ACCEPT) begin
                            hdr_valid_q  <= 1'b1;
                            hdr_opcode_q <= h_opc;
                            nak_sent_q   <= 1'b0;
                            ackreq_q     <= h_ackreq;
                            if (!in_last)
                                state_q <= ST_PASS;
                        end else begin
                            if (cls == CLS_AHEAD)
                                nak_sent_q <= 1'b1;
                            if (!in_last)
                                state_q <= ST_DROP;
                        end
                    end
                    ST_PASS: begin
                        pl_valid_q <= 1'b1;
                        pl_data_q  <= in_data;
                        pl_last_q  <= in_last;
                        if (in_last)
                            state_q <= ST_IDLE;
                    end
                    ST_DROP: begin
                        if (in_last)
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    rdma_ack_slot u_ack_slot (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_nak_i   (req_type == ACK_T_NAK),
        .req_psn_i   (req_psn),
        .ack_ready_i (ack_ready),
        .ack_valid_o (ack_valid),
        .ack_nak_o   (ack_nak),
        .ack_psn_o   (ack_psn)
    );

    assign pl_valid   = pl_valid_q;
    assign pl_data    = pl_data_q;
    assign pl_last    = pl_last_q;
    assign hdr_valid  = hdr_valid_q;
    assign hdr_opcode = hdr_opcode_q;
    assign epsn       = epsn_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rdma_rx_psn_chk.sv
// Directed vector bench for rdma_rx_psn_chk; second instance starts at ePSN 24'hFFFFFF
// to reach the wrap and half-window boundaries.
module tb_rdma_rx_psn_chk;

    localparam logic [23:0] QP = 24'h000011;

    typedef struct {
        logic        rst;
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        rdy;
        logic        e_plv;
        logic [63:0] e_pld;
        logic        e_pll;
        logic        e_hv;
        logic [7:0]  e_op;
        logic        e_av;
        logic        e_nak;
        logic [23:0] e_apsn;
        logic [23:0] e_epsn;
        logic [15:0] e_drop;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, v0, l0, rdy0, rst1, v1, l1, rdy1;
    logic [63:0] d0, d1;
    logic        plv0, pll0, hv0, av0, nak0, plv1, pll1, hv1, av1, nak1;
    logic [63:0] pld0, pld1;
    logic [7:0]  op0, op1;
    logic [23:0] apsn0, epsn0, apsn1, epsn1;
    logic [15:0] drop0, drop1;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    rdma_rx_psn_chk #(.QPN(QP), .PSN_INIT(24'h000000), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_data(d0), .in_last(l0),
        .pl_valid(plv0), .pl_data(pld0), .pl_last(pll0),
        .hdr_valid(hv0), .hdr_opcode(op0),
        .ack_valid(av0), .ack_ready(rdy0), .ack_nak(nak0), .ack_psn(apsn0),
        .epsn(epsn0), .drop_cnt(drop0)
    );

    rdma_rx_psn_chk #(.QPN(QP), .PSN_INIT(24'hFFFFFF), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1), .in_last(l1),
        .pl_valid(plv1), .pl_data(pld1), .pl_last(pll1),
        .hdr_valid(hv1), .hdr_opcode(op1),
        .ack_valid(av1), .ack_ready(rdy1), .ack_nak(nak1), .ack_psn(apsn1),
        .epsn(epsn1), .drop_cnt(drop1)
    );

    function automatic logic [63:0] H(input logic [7:0] op, input logic [23:0] qp,
                                      input logic ar, input logic [23:0] psn);
        return {op, qp, ar, 7'h00, psn};
    endfunction

    function automatic logic [63:0] P(input int unsigned k);
        return 64'hC0DE_0000_0000_0000 + 64'(k);
    endfunction

    function automatic vec_t mk(input logic rst, input logic v, input logic [63:0] d,
                                input logic l, input logic rdy,
                                input logic plv, input logic [63:0] pld, input logic pll,
                                input logic hv, input logic [7:0] op,
                                input logic av, input logic nak, input logic [23:0] apsn,
                                input logic [23:0] ep, input logic [15:0] dr);
        vec_t x;
        x.rst = rst; x.v = v; x.d = d; x.l = l; x.rdy = rdy;
        x.e_plv = plv; x.e_pld = pld; x.e_pll = pll;
        x.e_hv = hv; x.e_op = op;
        x.e_av = av; x.e_nak = nak; x.e_apsn = apsn;
        x.e_epsn = ep; x.e_drop = dr;
        return x;
    endfunction

    task automatic chk(input string tag, input string f, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", tag, f, act, exp);
        end
    endtask

    task automatic run_vec(input int which, input vec_t x, input string tag);
        logic        plv, pll, hv, av, nak;
        logic [63:0] pld;
        logic [7:0]  op;
        logic [23:0] apsn, ep;
        logic [15:0] dr;
        if (which == 0) begin
            rst0 = x.rst; v0 = x.v; d0 = x.d; l0 = x.l; rdy0 = x.rdy;
        end else begin
            rst1 = x.rst; v1 = x.v; d1 = x.d; l1 = x.l; rdy1 = x.rdy;
        end
        @(posedge clk);
        #1;
        if (which == 0) begin
            plv = plv0; pld = pld0; pll = pll0; hv = hv0; op = op0;
            av = av0; nak = nak0; apsn = apsn0; ep = epsn0; dr = drop0;
        end else begin
            plv = plv1; pld = pld1; pll = pll1; hv = hv1; op = op1;
            av = av1; nak = nak1; apsn = apsn1; ep = epsn1; dr = drop1;
        end
        chk(tag, "pl_valid", 64'(plv), 64'(x.e_plv));
        if (x.e_plv) begin
            chk(tag, "pl_data", pld, x.e_pld);
            chk(tag, "pl_last", 64'(pll), 64'(x.e_pll));
        end
        chk(tag, "hdr_valid", 64'(hv), 64'(x.e_hv));
        if (x.e_hv)
            chk(tag, "hdr_opcode", 64'(op), 64'(x.e_op));
        chk(tag, "ack_valid", 64'(av), 64'(x.e_av));
        if (x.e_av) begin
            chk(tag, "ack_nak", 64'(nak), 64'(x.e_nak));
            chk(tag, "ack_psn", 64'(apsn), 64'(x.e_apsn));
        end
        chk(tag, "epsn", 64'(ep), 64'(x.e_epsn));
        chk(tag, "drop_cnt", 64'(dr), 64'(x.e_drop));
    endtask

    initial begin
        rst0 = 1'b1; v0 = 1'b0; d0 = '0; l0 = 1'b0; rdy0 = 1'b1;
        rst1 = 1'b1; v1 = 1'b0; d1 = '0; l1 = 1'b0; rdy1 = 1'b1;

        //   rst v  data                    l rdy plv pld    pll hv op     av nak apsn         epsn        drop
        tbl.push_back(mk(0,1,H(8'h04,QP,0,24'd0),0,1, 0,'0,0,   1,8'h04, 0,0,24'd0,  24'd0, 16'd0));
        tbl.push_back(mk(0,1,P(0),0,1,                1,P(0),0, 0,8'h00, 0,0,24'd0,  24'd0, 16'd0));
        tbl.push_back(mk(0,1,P(1),0,1,                1,P(1),0, 0,8'h00, 0,0,24'd0,  24'd0, 16'd0));
        tbl.push_back(mk(0,1,P(2),1,1,                1,P(2),1, 0,8'h00, 0,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,1,H(8'h05,QP,0,24'd1),0,1, 0,'0,0,   1,8'h05, 0,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,1,P(3),0,1,                1,P(3),0, 0,8'h00, 0,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,0,P(99),1,1,               0,'0,0,   0,8'h00, 0,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,1,P(4),0,1,                1,P(4),0, 0,8'h00, 0,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,1,P(5),1,1,                1,P(5),1, 0,8'h00, 0,0,24'd0,  24'd2, 16'd0));
        tbl.push_back(mk(0,1,H(8'h06,QP,1,24'd2),0,1, 0,'0,0,   1,8'h06, 0,0,24'd0,  24'd2, 16'd0));
        tbl.push_back(mk(0,1,P(6),0,1,                1,P(6),0, 0,8'h00, 0,0,24'd0,  24'd2, 16'd0));
        tbl.push_back(mk(0,1,P(7),0,1,                1,P(7),0, 0,8'h00, 0,0,24'd0,  24'd2, 16'd0));
        tbl.push_back(mk(0,1,P(8),1,1,                1,P(8),1, 0,8'h00, 1,0,24'd2,  24'd3, 16'd0));
        tbl.push_back(mk(0,0,'0,0,1,                  0,'0,0,   0,8'h00, 0,0,24'd0,  24'd3, 16'd0));
        tbl.push_back(mk(0,1,H(8'h01,QP,0,24'd3),1,1, 0,'0,0,   1,8'h01, 0,0,24'd0,  24'd4, 16'd0));
        tbl.push_back(mk(0,1,H(8'h01,QP,0,24'd4),1,1, 0,'0,0,   1,8'h01, 0,0,24'd0,  24'd5, 16'd0));
        // duplicate PSN 3 at ePSN 5
        tbl.push_back(mk(0,1,H(8'h07,QP,0,24'd3),0,1, 0,'0,0,   0,8'h00, 1,0,24'd4,  24'd5, 16'd1));
        tbl.push_back(mk(0,1,P(9),1,1,                0,'0,0,   0,8'h00, 0,0,24'd0,  24'd5, 16'd1));
        // ahead: PSN 7 then 8 -> single NAK
        tbl.push_back(mk(0,1,H(8'h01,QP,0,24'd7),1,1, 0,'0,0,   0,8'h00, 1,1,24'd5,  24'd5, 16'd2));
        tbl.push_back(mk(0,1,H(8'h01,QP,0,24'd8),1,1, 0,'0,0,   0,8'h00, 0,0,24'd0,  24'd5, 16'd3));
        tbl.push_back(mk(0,1,H(8'h08,QP,0,24'd5),0,1, 0,'0,0,   1,8'h08, 0,0,24'd0,  24'd5, 16'd3));
        tbl.push_back(mk(0,1,P(10),1,1,               1,P(10),1,0,8'h00, 0,0,24'd0,  24'd6, 16'd3));
        tbl.push_back(mk(0,1,H(8'h01,QP,0,24'd9),1,1, 0,'0,0,   0,8'h00, 1,1,24'd6,  24'd6, 16'd4));
        // QP mismatch with ackreq: dropped, no ACK
        tbl.push_back(mk(0,1,H(8'h01,24'h000012,1,24'd6),1,1, 0,'0,0, 0,8'h00, 0,0,24'd0, 24'd6, 16'd5));
        // coalescing with ack_ready low
        tbl.push_back(mk(0,1,H(8'h02,QP,1,24'd6),1,0, 0,'0,0,   1,8'h02, 1,0,24'd6,  24'd7, 16'd5));
        tbl.push_back(mk(0,1,H(8'h02,QP,1,24'd7),1,0, 0,'0,0,   1,8'h02, 1,0,24'd7,  24'd8, 16'd5));
        tbl.push_back(mk(0,1,H(8'h02,QP,1,24'd8),1,0, 0,'0,0,   1,8'h02, 1,0,24'd8,  24'd9, 16'd5));
        tbl.push_back(mk(0,0,'0,0,0,                  0,'0,0,   0,8'h00, 1,0,24'd8,  24'd9, 16'd5));
        tbl.push_back(mk(0,0,'0,0,1,                  0,'0,0,   0,8'h00, 0,0,24'd0,  24'd9, 16'd5));
        tbl.push_back(mk(0,1,H(8'h02,QP,1,24'd9),1,0, 0,'0,0,   1,8'h02, 1,0,24'd9,  24'd10, 16'd5));
        tbl.push_back(mk(0,1,H(8'h02,QP,1,24'd10),1,1,0,'0,0,   1,8'h02, 1,0,24'd10, 24'd11, 16'd5));
        tbl.push_back(mk(0,0,'0,0,1,                  0,'0,0,   0,8'h00, 0,0,24'd0,  24'd11, 16'd5));
        // reset in the middle of a PASS packet
        tbl.push_back(mk(0,1,H(8'h09,QP,0,24'd11),0,1,0,'0,0,   1,8'h09, 0,0,24'd0,  24'd11, 16'd5));
        tbl.push_back(mk(0,1,P(11),0,1,               1,P(11),0,0,8'h00, 0,0,24'd0,  24'd11, 16'd5));
        tbl.push_back(mk(1,1,P(12),0,1,               0,'0,0,   0,8'h00, 0,0,24'd0,  24'd0, 16'd0));
        tbl.push_back(mk(0,1,H(8'h0A,QP,1,24'd0),1,1, 0,'0,0,   1,8'h0A, 1,0,24'd0,  24'd1, 16'd0));
        tbl.push_back(mk(0,0,'0,0,1,                  0,'0,0,   0,8'h00, 0,0,24'd0,  24'd1, 16'd0));

        // reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst0", "pl_valid", 64'(plv0), 64'd0);
        chk("rst0", "hdr_valid", 64'(hv0), 64'd0);
        chk("rst0", "hdr_opcode", 64'(op0), 64'd0);
        chk("rst0", "ack_valid", 64'(av0), 64'd0);
        chk("rst0", "epsn", 64'(epsn0), 64'd0);
        chk("rst0", "drop_cnt", 64'(drop0), 64'd0);
        chk("rst1", "epsn", 64'(epsn1), 64'hFFFFFF);
        chk("rst1", "ack_psn", 64'(apsn1), 64'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        foreach (tbl[i])
            run_vec(0, tbl[i], $sformatf("v%0d", i));

        // wrap and half-window boundaries on the instance starting at 24'hFFFFFF
        run_vec(1, mk(0,1,H(8'h03,QP,1,24'hFFFFFF),1,1, 0,'0,0, 1,8'h03, 1,0,24'hFFFFFF, 24'd0, 16'd0), "w0");
        run_vec(1, mk(0,1,H(8'h04,QP,0,24'd0),0,1,      0,'0,0, 1,8'h04, 0,0,24'd0, 24'd0, 16'd0), "w1");
        run_vec(1, mk(0,1,P(20),1,1,                    1,P(20),1, 0,8'h00, 0,0,24'd0, 24'd1, 16'd0), "w2");
        run_vec(1, mk(0,1,H(8'h01,QP,0,24'h800001),1,1, 0,'0,0, 0,8'h00, 1,0,24'd0, 24'd1, 16'd1), "w3");
        run_vec(1, mk(0,1,H(8'h01,QP,0,24'h800000),1,1, 0,'0,0, 0,8'h00, 1,1,24'd1, 24'd1, 16'd2), "w4");
        run_vec(1, mk(0,0,'0,0,1,                       0,'0,0, 0,8'h00, 0,0,24'd0, 24'd1, 16'd2), "w5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
